axi_tx: RTL and testbench

//  AXI-Stream transmitter. It is the egress counterpart of the packed-byte receive path.
//  It takes packed beats (valid bytes low-aligned, count given as last-byte index) from dataplane logic.
//  It emits AXI-Stream beats with generated tkeep/tlast and full tready backpressure.
//  It buffers 2 beats, enforces a maximum packet length (truncate + drop remainder) and counts packets.

---
 rtl/axi_stream_pkg.sv | 13 +
 rtl/axi_tx_fifo.sv | 46 ++++
 rtl/axi_tx.sv | 99 +++++++++
 tb/tb_axi_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - shared types and keep-mask helper for the AXI-Stream transmit path
package axi_stream_pkg;

   localparam int MAX_KEEP = 128;

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} tx_state_t;

   // Low-contiguous byte-enable mask with idx+1 ones; callers size-cast to their keep width.
   function automatic logic [MAX_KEEP-1:0] keep_from_idx(input int unsigned idx);
      return {MAX_KEEP{1'b1}} >> (MAX_KEEP - 1 - idx);
   endfunction

endpackage

// File: rtl/axi_tx_fifo.sv
// rtl/axi_tx_fifo.sv - two-entry register FIFO with occupancy count and head output
module axi_tx_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && (count != 2'd2);
   assign do_pop  = pop && (count != 2'd0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_tx.sv
// rtl/axi_tx.sv - packed-beat to AXI-Stream transmitter with length limit and packet counter
module axi_tx
   import axi_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BEATS  = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [$clog2(DATA_WIDTH/8)-1:0] in_idx,
   input  logic                          in_last,
   output logic                          tvalid,
   input  logic                          tready,
   output logic [DATA_WIDTH-1:0]         tdata,
   output logic [DATA_WIDTH/8-1:0]       tkeep,
   output logic                          tlast,
   output logic                          trunc,
   output logic [31:0]                   pkt_count
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(MAX_BEATS + 1);
   localparam int PW     = DATA_WIDTH + KEEP_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   tx_state_t         state;
   logic [CNT_W-1:0]  beat_cnt;
   logic [1:0]        fifo_count;
   logic [PW-1:0]     head;
   logic [KEEP_W-1:0] in_keep;
   logic              accept;
   logic              push;
   logic              pop;
   logic              at_limit;
   logic              push_last;

   // DROP swallows the remainder of an over-long packet, so it never waits on FIFO space.
   assign in_ready  = rst_n && ((state == DROP) || (fifo_count < 2'd2));
   assign accept    = in_valid && in_ready;
   assign push      = accept && (state != DROP);
   assign at_limit  = (state == IDLE) ? (MAX_BEATS == 1) : (beat_cnt == LAST_CNT);
   assign push_last = in_last || at_limit;
   assign in_keep   = KEEP_W'(keep_from_idx(32'(in_idx)));

   assign tvalid = (fifo_count != 2'd0);
   assign pop    = tvalid && tready;
   assign {tdata, tkeep, tlast} = head;

   axi_tx_fifo #(.W(PW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({in_data, in_keep, push_last}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         trunc     <= 1'b0;
         pkt_count <= '0;
      end else begin
         trunc <= 1'b0;
         if (pop && tlast)
            pkt_count <= pkt_count + 32'd1;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (!in_last && (MAX_BEATS != 1)) begin
                     state    <= ACTIVE;
                     beat_cnt <= CNT_W'(1);
                  end
               end
               ACTIVE: begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if (in_last) begin
                     state <= IDLE;
                  end else if (at_limit) begin
                     trunc <= 1'b1;
                     state <= DROP;
                  end
               end
               DROP: begin
                  if (in_last)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi_tx.sv
// tb/tb_axi_tx.sv - directed self-checking bench for axi_tx at 64-bit data, 4-beat limit
module tb_axi_tx;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [2:0]  in_idx;
   logic        in_last;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        trunc;
   logic [31:0] pkt_count;

   int vectors;
   int miscompares;

   logic [63:0] d2 [3] = '{64'hA000_0000_0000_0001, 64'hA000_0000_0000_0002, 64'h0000_0000_00A0_0003};
   logic [63:0] d3 [4] = '{64'hB0B0_0000_0000_0010, 64'hB0B0_0000_0000_0011, 64'hB0B0_0000_0000_0012, 64'hB0B0_0000_0000_0013};
   logic [63:0] d4 [6] = '{64'hC4C4_0000_0000_0020, 64'hC4C4_0000_0000_0021, 64'hC4C4_0000_0000_0022,
                           64'hC4C4_0000_0000_0023, 64'hC4C4_0000_0000_0024, 64'hC4C4_0000_0000_0025};
   logic [63:0] d5 [4] = '{64'hD5D5_0000_0000_0030, 64'hD5D5_0000_0000_0031, 64'hD5D5_0000_0000_0032, 64'hD5D5_0000_0000_0033};

   axi_tx #(.DATA_WIDTH(64), .MAX_BEATS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_idx    (in_idx),
      .in_last   (in_last),
      .tvalid    (tvalid),
      .tready    (tready),
      .tdata     (tdata),
      .tkeep     (tkeep),
      .tlast     (tlast),
      .trunc     (trunc),
      .pkt_count (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] idx, input logic last);
      in_valid = v;
      in_data  = d;
      in_idx   = idx;
      in_last  = last;
   endtask

   task automatic chk_head(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
      chk({tag, "_tvalid"}, 64'(tvalid), 64'd1);
      chk({tag, "_tdata"}, tdata, d);
      chk({tag, "_tkeep"}, 64'(tkeep), 64'(k));
      chk({tag, "_tlast"}, 64'(tlast), 64'(l));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n  = 1'b0;
      tready = 1'b1;
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tdata", tdata, 64'd0);
      chk("rst_tkeep", 64'(tkeep), 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      chk("rst_trunc", 64'(trunc), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // single full beat
      drive(1'b1, 64'h1122_3344_5566_7788, 3'd7, 1'b1);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t1", 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
      tick();
      chk("t1_pkt_count", 64'(pkt_count), 64'd1);
      chk("t1_tvalid_after", 64'(tvalid), 64'd0);

      // three beats, short final beat
      drive(1'b1, d2[0], 3'd7, 1'b0);
      tick();
      drive(1'b1, d2[1], 3'd7, 1'b0);
      chk_head("t2_b0", d2[0], 8'hFF, 1'b0);
      tick();
      drive(1'b1, d2[2], 3'd2, 1'b1);
      chk_head("t2_b1", d2[1], 8'hFF, 1'b0);
      chk("t2_in_ready", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t2_b2", d2[2], 8'h07, 1'b1);
      chk("t2_trunc", 64'(trunc), 64'd0);
      tick();
      chk("t2_pkt_count", 64'(pkt_count), 64'd2);
      chk("t2_tvalid_after", 64'(tvalid), 64'd0);

      // backpressure for five edges while four beats are offered
      tready = 1'b0;
      drive(1'b1, d3[0], 3'd7, 1'b0);
      tick();
      drive(1'b1, d3[1], 3'd7, 1'b0);
      chk("t3_in_ready_1", 64'(in_ready), 64'd1);
      tick();
      drive(1'b1, d3[2], 3'd7, 1'b0);
      chk("t3_in_ready_full", 64'(in_ready), 64'd0);
      chk_head("t3_hold_e2", d3[0], 8'hFF, 1'b0);
      tick();
      chk("t3_hold_e3", tdata, d3[0]);
      chk("t3_in_ready_e3", 64'(in_ready), 64'd0);
      tick();
      chk("t3_hold_e4", tdata, d3[0]);
      tick();
      chk("t3_hold_e5", tdata, d3[0]);
      chk("t3_in_ready_e5", 64'(in_ready), 64'd0);
      tready = 1'b1;
      tick();
      chk_head("t3_b1", d3[1], 8'hFF, 1'b0);
      chk("t3_in_ready_drain", 64'(in_ready), 64'd1);
      tick();
      drive(1'b1, d3[3], 3'd7, 1'b1);
      chk_head("t3_b2", d3[2], 8'hFF, 1'b0);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t3_b3", d3[3], 8'hFF, 1'b1);
      chk("t3_trunc", 64'(trunc), 64'd0);
      tick();
      chk("t3_pkt_count", 64'(pkt_count), 64'd3);
      chk("t3_tvalid_after", 64'(tvalid), 64'd0);

      // six-beat packet truncated at beat four
      drive(1'b1, d4[0], 3'd7, 1'b0);
      tick();
      drive(1'b1, d4[1], 3'd7, 1'b0);
      chk_head("t4_b0", d4[0], 8'hFF, 1'b0);
      tick();
      drive(1'b1, d4[2], 3'd7, 1'b0);
      chk_head("t4_b1", d4[1], 8'hFF, 1'b0);
      tick();
      drive(1'b1, d4[3], 3'd7, 1'b0);
      chk_head("t4_b2", d4[2], 8'hFF, 1'b0);
      chk("t4_trunc_pre", 64'(trunc), 64'd0);
      tick();
      drive(1'b1, d4[4], 3'd7, 1'b0);
      chk_head("t4_b3", d4[3], 8'hFF, 1'b1);
      chk("t4_trunc_pulse", 64'(trunc), 64'd1);
      chk("t4_in_ready_drop", 64'(in_ready), 64'd1);
      tick();
      drive(1'b1, d4[5], 3'd7, 1'b1);
      chk("t4_trunc_end", 64'(trunc), 64'd0);
      chk("t4_drop_tvalid_a", 64'(tvalid), 64'd0);
      chk("t4_pkt_count_trunc", 64'(pkt_count), 64'd4);
      tick();
      drive(1'b1, 64'h0000_0000_E1E2_E3E4, 3'd3, 1'b1);
      chk("t4_drop_tvalid_b", 64'(tvalid), 64'd0);
      chk("t4_trunc_quiet", 64'(trunc), 64'd0);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t4_next", 64'h0000_0000_E1E2_E3E4, 8'h0F, 1'b1);
      tick();
      chk("t4_pkt_count_next", 64'(pkt_count), 64'd5);
      chk("t4_tvalid_after", 64'(tvalid), 64'd0);

      // exactly four beats ending on in_last: no truncation
      drive(1'b1, d5[0], 3'd7, 1'b0);
      tick();
      drive(1'b1, d5[1], 3'd7, 1'b0);
      chk_head("t5_b0", d5[0], 8'hFF, 1'b0);
      tick();
      drive(1'b1, d5[2], 3'd7, 1'b0);
      chk_head("t5_b1", d5[1], 8'hFF, 1'b0);
      tick();
      drive(1'b1, d5[3], 3'd7, 1'b1);
      chk_head("t5_b2", d5[2], 8'hFF, 1'b0);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t5_b3", d5[3], 8'hFF, 1'b1);
      chk("t5_trunc", 64'(trunc), 64'd0);
      tick();
      chk("t5_trunc_after", 64'(trunc), 64'd0);
      chk("t5_pkt_count", 64'(pkt_count), 64'd6);

      // reset with two beats buffered
      tready = 1'b0;
      drive(1'b1, 64'hF0F0_0000_0000_0001, 3'd7, 1'b0);
      tick();
      drive(1'b1, 64'hF0F0_0000_0000_0002, 3'd7, 1'b0);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk("t6_tvalid_buffered", 64'(tvalid), 64'd1);
      chk("t6_in_ready_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("t6_tvalid_in_rst", 64'(tvalid), 64'd0);
      chk("t6_in_ready_in_rst", 64'(in_ready), 64'd0);
      chk("t6_pkt_count_in_rst", 64'(pkt_count), 64'd0);
      tick();
      rst_n  = 1'b1;
      tready = 1'b1;
      drive(1'b1, 64'h0000_0000_0000_005A, 3'd0, 1'b1);
      #1;
      chk("t6_in_ready_post", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 64'd0, 3'd0, 1'b0);
      chk_head("t6_new", 64'h0000_0000_0000_005A, 8'h01, 1'b1);
      tick();
      chk("t6_pkt_count", 64'(pkt_count), 64'd1);
      chk("t6_tvalid_after", 64'(tvalid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
